// File: rtl/heap_root_ctrl.sv
// Root (level-0) stage of the top-K min-heap sorter.
// Holds the heap minimum, replaces it with strictly larger incoming items,
// pushes each replacement to level 1 and takes back the level-1 write-back
// as the new root. Also sequences heap initialisation and counts
// accepted / dropped items with saturating counters.
module heap_root_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    KEY_WIDTH  = 16,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] INIT_DATA  = '0,
    parameter int                    INIT_WAIT  = 32,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_init,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  init_out,
    output logic                  nl_update_out,
    output logic [ADDR_WIDTH-1:0] nl_addr_out,
    output logic                  nl_branch_out,
    output logic [DATA_WIDTH-1:0] nl_out,
    input  logic                  um_we,
    input  logic [DATA_WIDTH-1:0] um_in,
    output logic [DATA_WIDTH-1:0] root_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  accept_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam int                WAIT_W    = (INIT_WAIT > 1) ? $clog2(INIT_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_WAIT - 1);

    typedef enum logic [2:0] {
        ST_INIT_PULSE,
        ST_INIT,
        ST_IDLE,
        ST_PUSH,
        ST_WB
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              accept;
    logic              drop;
    logic              wb_load;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == {CNT_WIDTH{1'b1}}) ? c : c + CNT_WIDTH'(1);
    endfunction

    // Unsigned key comparison on the low KEY_WIDTH bits; ties are not "greater".
    function automatic logic key_gt(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
        return a[KEY_WIDTH-1:0] > b[KEY_WIDTH-1:0];
    endfunction

    assign nl_addr_out   = '0;
    assign nl_branch_out = 1'b0;
    assign busy          = (state != ST_IDLE);

    // State register; reset always lands in INIT_PULSE so the heap is re-initialised.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT_PULSE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake / strobe decode.
    always_comb begin
        state_next    = state;
        s_ready       = 1'b0;
        nl_update_out = 1'b0;
        accept        = 1'b0;
        drop          = 1'b0;
        wb_load       = 1'b0;
        // Held low while rst is asserted so the levels see exactly one pulse after release.
        init_out      = (state == ST_INIT_PULSE) && !rst;
        case (state)
            ST_INIT_PULSE: begin
                state_next = ST_INIT;
            end
            ST_INIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (start_init) begin
                    state_next = ST_INIT_PULSE;
                end else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        if (key_gt(s_data, root_data)) begin
                            accept     = 1'b1;
                            state_next = ST_PUSH;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
            end
            ST_PUSH: begin
                nl_update_out = 1'b1;
                state_next    = ST_WB;
            end
            ST_WB: begin
                wb_load    = um_we;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_INIT_PULSE;
            end
        endcase
    end

    // Init wait counter: cleared on the init pulse, counts through INIT.
    always_ff @(posedge clk) begin
        if (rst || state == ST_INIT_PULSE) begin
            wait_cnt <= '0;
        end else if (state == ST_INIT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Root and push register: accept loads both, write-back only touches the root.
    always_ff @(posedge clk) begin
        if (rst) begin
            root_data <= INIT_DATA;
            nl_out    <= INIT_DATA;
        end else if (state == ST_INIT_PULSE) begin
            root_data <= INIT_DATA;
        end else if (accept) begin
            root_data <= s_data;
            nl_out    <= s_data;
        end else if (wb_load) begin
            root_data <= um_in;
        end
    end

    // Accept / drop statistics; only rst clears them, re-initialisation keeps them.
    always_ff @(posedge clk) begin
        if (rst) begin
            accept_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (accept) begin
                accept_cnt <= sat_inc(accept_cnt);
            end
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule
